// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Instruction-fetch front end. Owns the PC, fetches one
//               instruction per cycle from a combinational instruction
//               memory and buffers it in a DEPTH-entry circular queue that
//               decode drains through a valid/ready handshake. EX redirects
//               flush the queue and retarget the PC.
//               Optional static branch prediction: STATIC_PREDICT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [31:0]                dec_inst,
    output logic [XLEN-1:0]            dec_pc,
    output logic [XLEN-1:0]            dec_pc4,
    output logic                       dec_pred_taken,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
);

    localparam int              c_ptrW   = $clog2(DEPTH);
    localparam int              c_cntW   = $clog2(DEPTH+1);
    localparam logic [31:0]     c_nopInst = 32'h0000_0013;
    localparam logic [XLEN-1:0] c_pcStep  = XLEN'(4);

    // Queue storage, one slot per entry {inst, pc, pred_taken}
    logic [31:0]       r_instMem [DEPTH];
    logic [XLEN-1:0]   r_pcMem   [DEPTH];
    logic              r_predMem [DEPTH];

    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_cntW-1:0] r_count;
    logic [XLEN-1:0]   r_pc;

    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_predTaken;
    logic [XLEN-1:0]   w_nextPc;

    // Handshake: valid comes only from registered occupancy, never from dec_ready
    always_comb begin
        w_empty = (r_count == '0);
        w_pop   = !w_empty && dec_ready && !redirect;
        w_push  = !redirect && ((r_count < c_cntW'(DEPTH)) || w_pop);
    end

`ifdef STATIC_PREDICT_EN
    logic [XLEN-1:0] w_jImm;
    logic [XLEN-1:0] w_bImm;

    // Static predictor: JAL always taken, backward conditional branches taken
    always_comb begin
        w_jImm = {{(XLEN-21){imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                  imem_rdata[20], imem_rdata[30:21], 1'b0};
        w_bImm = {{(XLEN-13){imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};
        w_predTaken = 1'b0;
        w_nextPc    = r_pc + c_pcStep;
        if (imem_rdata[6:0] == 7'b1101111) begin
            w_predTaken = 1'b1;
            w_nextPc    = r_pc + w_jImm;
        end else if ((imem_rdata[6:0] == 7'b1100011) && imem_rdata[31]) begin
            w_predTaken = 1'b1;
            w_nextPc    = r_pc + w_bImm;
        end
    end
`else
    // Sequential fetch only
    always_comb begin
        w_predTaken = 1'b0;
        w_nextPc    = r_pc + c_pcStep;
    end
`endif

    // PC, pointers and occupancy; reset beats redirect beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc    <= w_nextPc;
                r_wrPtr <= r_wrPtr + c_ptrW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_ptrW'(1);
            end
            r_count <= r_count + c_cntW'(w_push) - c_cntW'(w_pop);
        end
    end

    // Entry write; data slots need no reset because head outputs are masked when empty
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_instMem[r_wrPtr] <= imem_rdata;
            r_pcMem[r_wrPtr]   <= r_pc;
            r_predMem[r_wrPtr] <= w_predTaken;
        end
    end

    // Head outputs from registered queue data, forced to idle values when empty
    always_comb begin
        imem_addr      = r_pc;
        fq_count       = r_count;
        dec_valid      = !w_empty;
        dec_inst       = w_empty ? c_nopInst : r_instMem[r_rdPtr];
        dec_pc         = w_empty ? '0        : r_pcMem[r_rdPtr];
        dec_pred_taken = w_empty ? 1'b0      : r_predMem[r_rdPtr];
        dec_pc4        = dec_pc + c_pcStep;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Self-checking bench for fetch_queue_unit with a queue-based
//               reference model of the fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc4;
    logic        dec_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  fq_count;

    int nCompared   = 0;
    int nMismatched = 0;

    // One special memory word overrides the generated content
    logic [31:0] spAddr = 32'h1;
    logic [31:0] spInst = 32'h0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc;

    fetch_queue_unit #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_pc4(dec_pc4),
        .dec_pred_taken(dec_pred_taken),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == spAddr) return spInst;
        return {a[24:2] ^ 23'h5A5A5A, 2'b10, 7'b0010011};
    endfunction

    // Instruction memory: combinational read of the address the DUT presents
    always_comb imem_rdata = memWord(imem_addr);

    function automatic void predictModel(input logic [31:0] inst, input logic [31:0] pc,
                                         output logic taken, output logic [31:0] nxt);
        int off;
        taken = 1'b0;
        nxt   = pc + 32'd4;
`ifdef STATIC_PREDICT_EN
        if (inst[6:0] == 7'b1101111) begin
            off = int'({inst[19:12], inst[20], inst[30:21], 1'b0});
            if (inst[31]) off = off - (1 << 20);
            taken = 1'b1;
            nxt   = pc + 32'(off);
        end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
            off = int'({inst[7], inst[30:25], inst[11:8], 1'b0}) - 4096;
            taken = 1'b1;
            nxt   = pc + 32'(off);
        end
`endif
        off = 0;
    endfunction

    // Drive one cycle of inputs, advance the model, land on the next negedge
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc,
                         input logic rs);
        logic        doPop;
        logic        doPush;
        entry_t      e;
        logic [31:0] nxt;
        dec_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        rst         = rs;
        if (rs) begin
            mq.delete();
            mPc = RESET_PC;
        end else if (redir) begin
            mq.delete();
            mPc = {rpc[31:2], 2'b00};
        end else begin
            doPop  = (mq.size() > 0) && rdy;
            doPush = (mq.size() < DEPTH) || doPop;
            if (doPop) void'(mq.pop_front());
            if (doPush) begin
                e.inst = memWord(mPc);
                e.pc   = mPc;
                predictModel(e.inst, mPc, e.pred, nxt);
                mq.push_back(e);
                mPc = nxt;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0800, 1'b1);
        nCompared++; if (dec_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_valid got %0b want 0", dec_valid); end
        nCompared++; if (dec_inst !== NOP) begin nMismatched++; $display("FAIL reset_inst got %h want %h", dec_inst, NOP); end
        nCompared++; if (dec_pc !== 32'h0) begin nMismatched++; $display("FAIL reset_pc got %h want 0", dec_pc); end
        nCompared++; if (dec_pc4 !== 32'h4) begin nMismatched++; $display("FAIL reset_pc4 got %h want 4", dec_pc4); end
        nCompared++; if (dec_pred_taken !== 1'b0) begin nMismatched++; $display("FAIL reset_pred got %0b want 0", dec_pred_taken); end
        nCompared++; if (fq_count !== 3'd0) begin nMismatched++; $display("FAIL reset_count got %0d want 0", fq_count); end
        nCompared++; if (imem_addr !== RESET_PC) begin nMismatched++; $display("FAIL reset_imem got %h want %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 8; k++) begin
            nCompared++; if (imem_addr !== RESET_PC + 32'(4*k)) begin nMismatched++; $display("FAIL seq_imem got %h want %h", imem_addr, RESET_PC + 32'(4*k)); end
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            nCompared++; if (dec_valid !== 1'b1 || dec_pc !== RESET_PC + 32'(4*k)) begin nMismatched++; $display("FAIL seq_pc got %0b/%h want 1/%h", dec_valid, dec_pc, RESET_PC + 32'(4*k)); end
            nCompared++; if (dec_inst !== memWord(RESET_PC + 32'(4*k))) begin nMismatched++; $display("FAIL seq_inst got %h want %h", dec_inst, memWord(RESET_PC + 32'(4*k))); end
        end
    endtask

    task automatic test_stall_release();
        logic [31:0] base;
        base = dec_pc;
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        nCompared++; if (fq_count !== 3'd4) begin nMismatched++; $display("FAIL stall_count got %0d want 4", fq_count); end
        nCompared++; if (imem_addr !== base + 32'h10) begin nMismatched++; $display("FAIL stall_imem got %h want %h", imem_addr, base + 32'h10); end
        nCompared++; if (dec_pc !== base) begin nMismatched++; $display("FAIL stall_head got %h want %h", dec_pc, base); end
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            nCompared++; if (dec_pc !== base + 32'(4*k)) begin nMismatched++; $display("FAIL release_pc got %h want %h", dec_pc, base + 32'(4*k)); end
            nCompared++; if (fq_count !== 3'd4) begin nMismatched++; $display("FAIL full_pop_count got %0d want 4", fq_count); end
        end
    endtask

    task automatic test_redirect();
        cycle(1'b0, 1'b1, 32'h0000_0300, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        nCompared++; if (fq_count !== 3'd3) begin nMismatched++; $display("FAIL redir_pre_count got %0d want 3", fq_count); end
        cycle(1'b0, 1'b1, 32'h0000_0203, 1'b0);
        nCompared++; if (fq_count !== 3'd0 || dec_valid !== 1'b0) begin nMismatched++; $display("FAIL redir_flush got %0d/%0b want 0/0", fq_count, dec_valid); end
        nCompared++; if (imem_addr !== 32'h200) begin nMismatched++; $display("FAIL redir_imem got %h want 200", imem_addr); end
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        nCompared++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200) begin nMismatched++; $display("FAIL redir_head got %0b/%h want 1/200", dec_valid, dec_pc); end
        nCompared++; if (dec_pc4 !== 32'h204) begin nMismatched++; $display("FAIL redir_pc4 got %h want 204", dec_pc4); end
    endtask

    task automatic test_predict();
        logic        expPred;
        logic [31:0] expNext;
        for (int t = 0; t < 2; t++) begin
            spAddr = 32'h40;
            spInst = (t == 0) ? 32'hFE00_08E3 : 32'h0000_0463;
`ifdef STATIC_PREDICT_EN
            expPred = (t == 0);
            expNext = (t == 0) ? 32'h30 : 32'h44;
`else
            expPred = 1'b0;
            expNext = 32'h44;
`endif
            cycle(1'b1, 1'b1, 32'h40, 1'b0);
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            nCompared++; if (dec_pc !== 32'h40 || dec_pred_taken !== expPred) begin nMismatched++; $display("FAIL pred_flag got %h/%0b want 40/%0b", dec_pc, dec_pred_taken, expPred); end
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            nCompared++; if (dec_pc !== expNext) begin nMismatched++; $display("FAIL pred_next got %h want %h", dec_pc, expNext); end
        end
        spAddr = 32'h1;
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        nCompared++; if (dec_pc !== 32'hFFFF_FFFC || dec_pc4 !== 32'h0) begin nMismatched++; $display("FAIL wrap_top got %h/%h want fffffffc/0", dec_pc, dec_pc4); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        nCompared++; if (dec_pc !== 32'h0) begin nMismatched++; $display("FAIL wrap_zero got %h want 0", dec_pc); end
    endtask

    task automatic test_random();
        entry_t      h;
        logic [31:0] eInst, ePc, ePc4;
        logic        ePred;
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), $urandom,
                  ($urandom_range(0, 99) == 0));
            if (mq.size() == 0) begin
                eInst = NOP; ePc = 32'h0; ePred = 1'b0;
            end else begin
                h = mq[0];
                eInst = h.inst; ePc = h.pc; ePred = h.pred;
            end
            ePc4 = ePc + 32'd4;
            nCompared++; if (dec_valid !== (mq.size() > 0) || fq_count !== 3'(mq.size())) begin nMismatched++; $display("FAIL rand_occ got %0b/%0d want %0b/%0d", dec_valid, fq_count, (mq.size() > 0), mq.size()); end
            nCompared++; if (imem_addr !== mPc) begin nMismatched++; $display("FAIL rand_imem got %h want %h", imem_addr, mPc); end
            nCompared++; if (dec_inst !== eInst || dec_pc !== ePc || dec_pc4 !== ePc4 || dec_pred_taken !== ePred) begin nMismatched++; $display("FAIL rand_head got %h/%h/%h/%0b want %h/%h/%h/%0b", dec_inst, dec_pc, dec_pc4, dec_pred_taken, eInst, ePc, ePc4, ePred); end
        end
    endtask

    initial begin
        rst = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mPc = RESET_PC;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall_release();
        test_redirect();
        test_predict();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end for the pipelined RISC-V core. It owns the PC, fetches one instruction per cycle from the combinational instruction memory and buffers fetched instructions in a DEPTH-entry queue. Decode consumes the queue through a valid/ready handshake, which replaces the fixed IF/ID stall/flush pair. Redirects from EX (mispredict, jalr) flush the queue and retarget the PC.

## Interface
- XLEN, 32, PC/address width (≥32).
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, PC value after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  XLEN  current fetch PC to instruction memory.
- imem_rdata  in  32  instruction at imem_addr, same cycle (combinational read).
- dec_valid  out  1  queue head holds a valid instruction.
- dec_ready  in  1  decode accepts head this cycle (low = StallD).
- dec_inst  out  32  head instruction; 32'h00000013 (NOP) when empty.
- dec_pc  out  XLEN  head PC; 0 when empty.
- dec_pc4  out  XLEN  dec_pc+4; 4 when empty.
- dec_pred_taken  out  1  fetch predicted head as taken; 0 when empty.
- redirect  in  1  EX redirect request.
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0.
- fq_count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Entry = {inst, pc, pred_taken}. Circular buffer, rd/wr pointers of $clog2(DEPTH) bits, separate count 0..DEPTH.
- pop = dec_valid & dec_ready & !redirect.
- push = !redirect & (count < DEPTH | pop); full queue with simultaneous pop accepts a push.
- On push: entry written with imem_rdata and PC; PC ← next_pc. No push: PC holds.
- next_pc = PC+4, or predicted target when pred_taken (see Configuration).
- count ← count + push − pop.
- redirect (priority over push/pop, below rst): count ← 0, pointers ← 0, PC ← {redirect_pc[XLEN-1:2],2'b00}, no write, no pop. Instruction fetched in the redirect cycle is discarded.
- Head outputs are driven from the queue register array (registered data), forced to the empty values while count = 0.
- PC arithmetic is modulo 2^XLEN; wrap from 2^XLEN−4 to 0 is legal and silent.
- dec_pc4 computed combinationally from dec_pc.

## Timing
- Reset: PC=RESET_PC, count=0, dec_valid=0, dec_inst=NOP, dec_pc=0, dec_pc4=4, dec_pred_taken=0, fq_count=0; imem_addr=RESET_PC.
- Fetch-to-decode latency: 1 cycle (instruction at imem_addr in cycle N is at head in N+1 if queue was empty).
- Throughput: 1 instruction/cycle sustained while dec_ready=1.
- Redirect penalty: redirect in cycle N → imem_addr=target in N+1 → dec_valid=1 in N+2.
- dec_ready=0 with full queue: PC and imem_addr hold; no entry lost or duplicated.
- rst mid-operation overrides redirect and handshakes in that cycle.
- dec_valid never depends combinationally on dec_ready.

## Configuration
- STATIC_PREDICT_EN defined: fetch decodes imem_rdata; JAL (opcode 1101111) → pred_taken=1, next_pc=PC+sext(J-imm); B-type (1100011) with inst[31]=1 (backward) → pred_taken=1, next_pc=PC+sext(B-imm); all else pred_taken=0, PC+4. EX must redirect to PC+4 on a predicted-taken branch that resolves not-taken.
- Not defined: pred_taken always 0, next_pc always PC+4; prediction logic absent.

## Test plan
- Reset with RESET_PC=0x100, dec_ready=1, sequential ALU ops → imem_addr 0x100,0x104,…; dec_pc 0x100 first seen one cycle after reset release, one new dec_pc per cycle.
- dec_ready=0 for 10 cycles, DEPTH=4 → fq_count saturates at 4, imem_addr holds at base+0x10; release → dec_pc continues base, base+4,… with no gap or repeat.
- Full queue, dec_ready=1 same cycle as push → fq_count stays 4, one entry in, one out.
- redirect=1, redirect_pc=0x203 with 3 entries queued → next cycle fq_count=0, dec_valid=0, imem_addr=0x200; following cycle dec_pc=0x200.
- STATIC_PREDICT_EN, beq at 0x40 with offset −16 → dec_pred_taken=1 for 0x40, next dec_pc=0x30; forward beq offset +8 → pred 0, next 0x44; without macro both give 0x44.
- PC at 0xFFFFFFFC (XLEN=32), dec_ready=1 → following dec_pc=0x00000000.
